// File: rtl/bpu_pkg.sv
// Shared types for the branch prediction unit: prediction type encoding,
// BTB entry layout and counter helpers.
package bpu_pkg;

    typedef enum logic [1:0] {
        PD_NONE = 2'b00,
        PD_COND = 2'b01,
        PD_CALL = 2'b10,
        PD_RET  = 2'b11
    } pd_type_t;

    // Counter value given to a freshly allocated entry (weakly taken).
    localparam logic [1:0] CTR_INIT = 2'b10;

    // Widest tag any legal configuration can need (32 - 2 offset bits).
    // Narrower tags are stored zero-extended; the constant bits fold away.
    localparam int TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        pd_type_t             ptype;
        logic [1:0]           ctr;
        logic [31:0]          target;
    } btb_entry_t;

    // 2-bit saturating counter step: up on taken, down on not taken.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        nxt = ctr;
        if (up && ctr != 2'b11) begin
            nxt = ctr + 2'b01;
        end else if (!up && ctr != 2'b00) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpu_ras.sv
// Return-address stack with a circular pointer. A push on a full stack
// overwrites the oldest entry; a pop on an empty stack is ignored.
// Trained from the EX stage only, so it is never speculative.
module bpu_ras #(
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty
);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stack_q [RAS_DEPTH];
    logic [31:0]      stack_d [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;

    // Pointer/count next state; ptr points at the next free slot.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        stack_d = stack_q;
        if (push) begin
            stack_d[ptr_q] = push_data;
            ptr_d          = ptr_q + 1'b1;
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && cnt_q != '0) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state: cleared by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack storage: contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign top_ptr = ptr_q - 1'b1;
    assign top     = stack_q[top_ptr];
    assign empty   = (cnt_q == '0);

endmodule

// File: rtl/bpu_btb_ras.sv
// IF-stage branch predictor: direct-mapped BTB with 2-bit counters that
// predicts two sequential slots (IF_pc and IF_pc+4) per cycle and trains
// from the EX branch-update bundle.
// Optional return-address stack enabled by defining BPU_RAS_EN.
import bpu_pkg::*;

module bpu_btb_ras #(
    parameter int BTB_ENTRIES = 64,
    parameter int TAG_W       = 10,
    parameter int RAS_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        IF_valid,
    input  logic [31:0] IF_pc,
    output logic        IF_br_pd_a,
    output logic [31:0] IF_pc_pd_a,
    output logic [1:0]  IF_pd_type_a,
    output logic        IF_br_pd_b,
    output logic [31:0] IF_pc_pd_b,
    output logic [1:0]  IF_pd_type_b,
    input  logic [31:0] EX_pc_of_br,
    input  logic [1:0]  EX_pd_type,
    input  logic [31:0] EX_br_target,
    input  logic        EX_br_jump
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t       btb_q [BTB_ENTRIES];
    btb_entry_t       btb_d [BTB_ENTRIES];

    logic [31:0]      pc_a, pc_b;
    logic [IDX_W-1:0] idx_a, idx_b, ex_idx;
    logic [TAG_W-1:0] tag_a, tag_b, ex_tag;
    btb_entry_t       ent_a, ent_b, ex_old, ex_ent;
    logic             hit_a, hit_b, ex_hit;
    logic             tk_a, tk_b;
    logic [31:0]      tgt_a, tgt_b;
    logic             ras_avail;
    logic [31:0]      ras_top;
    logic             unused_pc_bits;

    assign pc_a   = IF_pc;
    assign pc_b   = IF_pc + 32'd4;
    assign idx_a  = pc_a[IDX_W+1:2];
    assign idx_b  = pc_b[IDX_W+1:2];
    assign tag_a  = pc_a[TAG_W+IDX_W+1:IDX_W+2];
    assign tag_b  = pc_b[TAG_W+IDX_W+1:IDX_W+2];
    assign ex_idx = EX_pc_of_br[IDX_W+1:2];
    assign ex_tag = EX_pc_of_br[TAG_W+IDX_W+1:IDX_W+2];

    // Offset and above-tag bits of the EX pc do not take part in indexing.
    assign unused_pc_bits = ^{EX_pc_of_br[1:0], EX_pc_of_br[31:TAG_W+IDX_W+2]};

    assign ent_a  = btb_q[idx_a];
    assign ent_b  = btb_q[idx_b];
    assign ex_old = btb_q[ex_idx];
    assign hit_a  = ent_a.valid && (ent_a.tag == TAG_MAX_W'(tag_a));
    assign hit_b  = ent_b.valid && (ent_b.tag == TAG_MAX_W'(tag_b));
    assign ex_hit = ex_old.valid && (ex_old.tag == TAG_MAX_W'(ex_tag));

`ifdef BPU_RAS_EN
    logic ras_push, ras_pop, ras_empty;

    assign ras_push  = (EX_pd_type == PD_CALL) && EX_br_jump;
    assign ras_pop   = (EX_pd_type == PD_RET);
    assign ras_avail = !ras_empty;

    bpu_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rstn      (rstn),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (EX_pc_of_br + 32'd4),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    assign ras_avail = 1'b0;
    assign ras_top   = 32'h0;
`endif

    // Combinational lookup; slot b is squashed when slot a redirects fetch.
    always_comb begin
        tk_a  = IF_valid && hit_a && (ent_a.ptype != PD_COND || ent_a.ctr[1]);
        tk_b  = IF_valid && hit_b && (ent_b.ptype != PD_COND || ent_b.ctr[1]);
        tgt_a = (ent_a.ptype == PD_RET && ras_avail) ? ras_top : ent_a.target;
        tgt_b = (ent_b.ptype == PD_RET && ras_avail) ? ras_top : ent_b.target;

        IF_br_pd_a   = tk_a;
        IF_pd_type_a = (IF_valid && hit_a) ? ent_a.ptype : PD_NONE;
        IF_pc_pd_a   = tk_a ? tgt_a : pc_a + 32'd4;

        IF_br_pd_b   = 1'b0;
        IF_pd_type_b = PD_NONE;
        IF_pc_pd_b   = pc_b + 32'd4;
        if (!tk_a) begin
            IF_br_pd_b   = tk_b;
            IF_pd_type_b = (IF_valid && hit_b) ? ent_b.ptype : PD_NONE;
            IF_pc_pd_b   = tk_b ? tgt_b : pc_b + 32'd4;
        end
    end

    // Training: counter update on hit, allocate on taken miss, one entry per cycle.
    always_comb begin
        btb_d  = btb_q;
        ex_ent = ex_old;
        if (EX_pd_type != PD_NONE) begin
            if (ex_hit) begin
                ex_ent.ctr = ctr_step(ex_old.ctr, EX_br_jump);
                if (EX_br_jump) begin
                    ex_ent.target = EX_br_target;
                    ex_ent.ptype  = pd_type_t'(EX_pd_type);
                end
            end else if (EX_br_jump) begin
                ex_ent.valid  = 1'b1;
                ex_ent.tag    = TAG_MAX_W'(ex_tag);
                ex_ent.ptype  = pd_type_t'(EX_pd_type);
                ex_ent.ctr    = CTR_INIT;
                ex_ent.target = EX_br_target;
            end
        end
        btb_d[ex_idx] = ex_ent;
    end

    // BTB array: cleared asynchronously so predictions drop to miss at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
        end else begin
            btb_q <= btb_d;
        end
    end

endmodule

// File: tb/tb_bpu_btb_ras.sv
// Directed bench for bpu_btb_ras. RAS scenarios run when BPU_RAS_EN is defined.
module tb_bpu_btb_ras;

    logic        clk;
    logic        rstn;
    logic        IF_valid;
    logic [31:0] IF_pc;
    logic        IF_br_pd_a, IF_br_pd_b;
    logic [31:0] IF_pc_pd_a, IF_pc_pd_b;
    logic [1:0]  IF_pd_type_a, IF_pd_type_b;
    logic [31:0] EX_pc_of_br;
    logic [1:0]  EX_pd_type;
    logic [31:0] EX_br_target;
    logic        EX_br_jump;

    int checks = 0;
    int errors = 0;

    bpu_btb_ras #(
        .BTB_ENTRIES (64),
        .TAG_W       (10),
        .RAS_DEPTH   (8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .IF_valid     (IF_valid),
        .IF_pc        (IF_pc),
        .IF_br_pd_a   (IF_br_pd_a),
        .IF_pc_pd_a   (IF_pc_pd_a),
        .IF_pd_type_a (IF_pd_type_a),
        .IF_br_pd_b   (IF_br_pd_b),
        .IF_pc_pd_b   (IF_pc_pd_b),
        .IF_pd_type_b (IF_pd_type_b),
        .EX_pc_of_br  (EX_pc_of_br),
        .EX_pd_type   (EX_pd_type),
        .EX_br_target (EX_br_target),
        .EX_br_jump   (EX_br_jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One EX update, applied on the next rising edge.
    task automatic upd(input logic [31:0] pc, input logic [1:0] t,
                       input logic [31:0] tgt, input logic j);
        @(negedge clk);
        EX_pc_of_br  = pc;
        EX_pd_type   = t;
        EX_br_target = tgt;
        EX_br_jump   = j;
        @(posedge clk);
        #1;
        EX_pd_type = 2'b00;
        EX_br_jump = 1'b0;
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc);
        IF_valid = v;
        IF_pc    = pc;
        #1;
    endtask

    initial begin
        rstn         = 1'b0;
        IF_valid     = 1'b1;
        IF_pc        = 32'h1C00_0000;
        EX_pc_of_br  = '0;
        EX_pd_type   = 2'b00;
        EX_br_target = '0;
        EX_br_jump   = 1'b0;
        #1;
        check("rst_br_a",   32'(IF_br_pd_a), 32'h0);
        check("rst_pc_a",   IF_pc_pd_a, 32'h1C00_0004);
        check("rst_pc_b",   IF_pc_pd_b, 32'h1C00_0008);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Cold BTB: everything misses.
        fetch(1'b1, 32'h1C00_0000);
        check("cold_br_a",   32'(IF_br_pd_a),   32'h0);
        check("cold_br_b",   32'(IF_br_pd_b),   32'h0);
        check("cold_type_a", 32'(IF_pd_type_a), 32'h0);
        check("cold_type_b", 32'(IF_pd_type_b), 32'h0);
        check("cold_pc_a",   IF_pc_pd_a,        32'h1C00_0004);
        check("cold_pc_b",   IF_pc_pd_b,        32'h1C00_0008);

        // Allocate COND in slot b's index and walk the counter.
        upd(32'h1C00_0004, 2'b01, 32'h1C00_0100, 1'b1);
        fetch(1'b1, 32'h1C00_0000);
        check("alloc_br_b",   32'(IF_br_pd_b),   32'h1);
        check("alloc_pc_b",   IF_pc_pd_b,        32'h1C00_0100);
        check("alloc_type_b", 32'(IF_pd_type_b), 32'h1);
        check("alloc_br_a",   32'(IF_br_pd_a),   32'h0);
        upd(32'h1C00_0004, 2'b01, 32'h1C00_0100, 1'b0);
        check("ctr01_br_b",   32'(IF_br_pd_b),   32'h0);
        check("ctr01_type_b", 32'(IF_pd_type_b), 32'h1);
        check("ctr01_pc_b",   IF_pc_pd_b,        32'h1C00_0008);
        upd(32'h1C00_0004, 2'b01, 32'h1C00_0100, 1'b0);
        check("ctr00_br_b", 32'(IF_br_pd_b), 32'h0);
        upd(32'h1C00_0004, 2'b01, 32'h1C00_0100, 1'b0);
        check("ctr00_sat_br_b", 32'(IF_br_pd_b), 32'h0);
        upd(32'h1C00_0004, 2'b01, 32'h1C00_0100, 1'b1);
        check("ctr_up01_br_b", 32'(IF_br_pd_b), 32'h0);
        upd(32'h1C00_0004, 2'b01, 32'h1C00_0100, 1'b1);
        check("ctr_up10_br_b", 32'(IF_br_pd_b), 32'h1);
        check("ctr_up10_pc_b", IF_pc_pd_b,      32'h1C00_0100);
        upd(32'h1C00_0004, 2'b01, 32'h1C00_0100, 1'b1);
        upd(32'h1C00_0004, 2'b01, 32'h1C00_0100, 1'b1);
        upd(32'h1C00_0004, 2'b01, 32'h1C00_0100, 1'b0);
        check("ctr11_sat_dn_br_b", 32'(IF_br_pd_b), 32'h1);
        upd(32'h1C00_0004, 2'b01, 32'h1C00_0100, 1'b0);
        check("ctr11_sat_dn2_br_b", 32'(IF_br_pd_b), 32'h0);
        upd(32'h1C00_0004, 2'b01, 32'h1C00_0100, 1'b1);
        check("retrain_br_b", 32'(IF_br_pd_b), 32'h1);

        // Slot a taken forces slot b to fall-through values.
        upd(32'h1C00_0000, 2'b01, 32'h1C00_0300, 1'b1);
        check("force_br_a",   32'(IF_br_pd_a),   32'h1);
        check("force_pc_a",   IF_pc_pd_a,        32'h1C00_0300);
        check("force_type_a", 32'(IF_pd_type_a), 32'h1);
        check("force_br_b",   32'(IF_br_pd_b),   32'h0);
        check("force_type_b", 32'(IF_pd_type_b), 32'h0);
        check("force_pc_b",   IF_pc_pd_b,        32'h1C00_0008);

        // Same index, different tag: miss on both slots.
        fetch(1'b1, 32'h1C00_0100);
        check("alias_br_a",   32'(IF_br_pd_a),   32'h0);
        check("alias_type_a", 32'(IF_pd_type_a), 32'h0);
        check("alias_pc_a",   IF_pc_pd_a,        32'h1C00_0104);
        check("alias_type_b", 32'(IF_pd_type_b), 32'h0);

        // Same-cycle update and lookup: old contents until the edge.
        @(negedge clk);
        EX_pc_of_br  = 32'h1C00_0000;
        EX_pd_type   = 2'b01;
        EX_br_target = 32'h1C00_0300;
        EX_br_jump   = 1'b0;
        fetch(1'b1, 32'h1C00_0000);
        check("samecyc_old_br_a", 32'(IF_br_pd_a), 32'h1);
        @(posedge clk);
        #1;
        EX_pd_type = 2'b00;
        #1;
        check("samecyc_new_br_a",   32'(IF_br_pd_a),   32'h0);
        check("samecyc_new_type_a", 32'(IF_pd_type_a), 32'h1);
        check("samecyc_new_br_b",   32'(IF_br_pd_b),   32'h1);
        check("samecyc_new_pc_b",   IF_pc_pd_b,        32'h1C00_0100);

        // Not-taken miss does not allocate.
        upd(32'h1C00_0040, 2'b01, 32'h1C00_0999, 1'b0);
        fetch(1'b1, 32'h1C00_0040);
        check("nomiss_alloc_type_a", 32'(IF_pd_type_a), 32'h0);
        check("nomiss_alloc_br_a",   32'(IF_br_pd_a),   32'h0);

        // CALL and RET entries predict taken to their BTB targets.
        upd(32'h1C00_0020, 2'b10, 32'h1C00_0500, 1'b1);
        fetch(1'b1, 32'h1C00_0020);
        check("call_br_a",   32'(IF_br_pd_a),   32'h1);
        check("call_type_a", 32'(IF_pd_type_a), 32'h2);
        check("call_pc_a",   IF_pc_pd_a,        32'h1C00_0500);
        upd(32'h1C00_0030, 2'b11, 32'h1C00_0777, 1'b1);
        fetch(1'b1, 32'h1C00_0030);
        check("ret_type_a", 32'(IF_pd_type_a), 32'h3);
        check("ret_pc_a",   IF_pc_pd_a,        32'h1C00_0777);

        // IF_valid low masks a trained hit.
        fetch(1'b0, 32'h1C00_0020);
        check("inval_br_a",   32'(IF_br_pd_a),   32'h0);
        check("inval_type_a", 32'(IF_pd_type_a), 32'h0);
        check("inval_pc_a",   IF_pc_pd_a,        32'h1C00_0024);
        check("inval_pc_b",   IF_pc_pd_b,        32'h1C00_0028);

        // 32-bit wrap of pc+4 / pc+8.
        fetch(1'b1, 32'hFFFF_FFFC);
        check("wrap_pc_a", IF_pc_pd_a, 32'h0000_0000);
        check("wrap_pc_b", IF_pc_pd_b, 32'h0000_0004);

        // Asynchronous reset mid-stream with a trained entry.
        fetch(1'b1, 32'h1C00_0020);
        check("pre_rst_br_a", 32'(IF_br_pd_a), 32'h1);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_br_a",   32'(IF_br_pd_a),   32'h0);
        check("async_rst_type_a", 32'(IF_pd_type_a), 32'h0);
        check("async_rst_pc_a",   IF_pc_pd_a,        32'h1C00_0024);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        check("post_rst_br_a", 32'(IF_br_pd_a), 32'h0);

`ifdef BPU_RAS_EN
        // RET entry first (pop on empty stack is ignored), then a CALL push.
        upd(32'h1C00_0204, 2'b11, 32'h0000_0000, 1'b1);
        fetch(1'b1, 32'h1C00_0204);
        check("ras_empty_pc_a", IF_pc_pd_a, 32'h0000_0000);
        upd(32'h1C00_0010, 2'b10, 32'h1C00_0200, 1'b1);
        fetch(1'b1, 32'h1C00_0204);
        check("ras_top_pc_a", IF_pc_pd_a, 32'h1C00_0014);
        check("ras_top_br_a", 32'(IF_br_pd_a), 32'h1);

        // Nine more pushes overflow the 8-deep stack.
        for (int k = 0; k < 9; k++) begin
            upd(32'h1C00_1000 + 32'(16 * k), 2'b10, 32'h1C00_2000, 1'b1);
        end
        fetch(1'b1, 32'h1C00_0204);
        check("ras_full_top", IF_pc_pd_a, 32'h1C00_1084);

        for (int j = 1; j <= 9; j++) begin
            logic [31:0] exp_top;
            upd(32'h1C00_0204, 2'b11, 32'h0000_0000, 1'b1);
            fetch(1'b1, 32'h1C00_0204);
            exp_top = (j < 8) ? 32'h1C00_1004 + 32'(16 * (8 - j)) : 32'h0000_0000;
            check($sformatf("ras_pop%0d", j), IF_pc_pd_a, exp_top);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
